// File: rtl/spmv_pkg.sv
// spmv_pkg: shared constants and the state type for the SpMV y-array responder
package spmv_pkg;
  localparam int Y_DEPTH = 8;
  localparam int Y_AW    = 3;
  localparam int DW      = 32;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;
endpackage

// File: rtl/spmv_dp_regfile.sv
// spmv_dp_regfile: dual-port register array, read-first, port 1 wins same-address writes
//   i_clr zeroes every word, i_en gates both access ports, q holds while its ce is low;
//   i_raddr/o_rdata is a combinational side read used by the drain stream.
module spmv_dp_regfile #(
  parameter int DEPTH = spmv_pkg::Y_DEPTH,
  parameter int AW    = spmv_pkg::Y_AW,
  parameter int DW    = spmv_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr0,
  input  logic          i_ce0,
  input  logic          i_we0,
  input  logic [DW-1:0] i_d0,
  output logic [DW-1:0] o_q0,
  input  logic [AW-1:0] i_addr1,
  input  logic          i_ce1,
  input  logic          i_we1,
  input  logic [DW-1:0] i_d1,
  output logic [DW-1:0] o_q1,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_ok0, w_ok1;
  assign w_ok0   = {1'b0, i_addr0} < LIM;
  assign w_ok1   = {1'b0, i_addr1} < LIM;
  assign o_rdata = r_mem[i_raddr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      o_q0 <= '0;
      o_q1 <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_en) begin
      // reads sample the array before this cycle's writes land (read-first)
      if (i_ce0) o_q0 <= w_ok0 ? r_mem[i_addr0] : '0;
      if (i_ce1) o_q1 <= w_ok1 ? r_mem[i_addr1] : '0;
      // out-of-range addresses never match a row, so those writes drop out
      for (int i = 0; i < DEPTH; i++)
        if (i_ce1 && i_we1 && i_addr1 == AW'(i)) r_mem[i] <= i_d1;
        else if (i_ce0 && i_we0 && i_addr0 == AW'(i)) r_mem[i] <= i_d0;
    end
endmodule

// File: rtl/spmv_y_responder.sv
// spmv_y_responder: register-backed y memory for the SpMV core with run sequencing and drain stream
//   start_in/ap_start/ap_done sequence one run; y_* are the core's two ap_memory ports;
//   m_* stream every y word after the run; busy is high outside IDLE.
module spmv_y_responder #(
  parameter int DEPTH = spmv_pkg::Y_DEPTH,
  parameter int AW    = spmv_pkg::Y_AW,
  parameter int DW    = spmv_pkg::DW
) (
  input  logic          clk,
  input  logic          ap_rst,
  input  logic          start_in,
  output logic          ap_start,
  input  logic          ap_done,
  input  logic [AW-1:0] y_address0,
  input  logic          y_ce0,
  input  logic          y_we0,
  input  logic [DW-1:0] y_d0,
  output logic [DW-1:0] y_q0,
  input  logic [AW-1:0] y_address1,
  input  logic          y_ce1,
  input  logic          y_we1,
  input  logic [DW-1:0] y_d1,
  output logic [DW-1:0] y_q1,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_index,
  output logic          m_last,
  output logic          busy
);
  import spmv_pkg::*;
  state_t        r_state, w_next;
  logic [AW-1:0] r_idx, w_idx_next;
  logic          w_xfer;
  assign ap_start = r_state == RUN;
  assign busy     = r_state != IDLE;
  assign m_valid  = r_state == DRAIN;
  assign m_index  = r_idx;
  assign m_last   = m_valid && r_idx == AW'(DEPTH - 1);
  assign w_xfer   = m_valid && m_ready;
  always_comb begin
    w_next = r_state == IDLE  ? (start_in ? CLEAR : IDLE) :
             r_state == CLEAR ? RUN :
             r_state == RUN   ? (ap_done ? DRAIN : RUN) :
             (w_xfer && m_last ? IDLE : DRAIN);
    w_idx_next = !w_xfer ? r_idx : m_last ? '0 : r_idx + AW'(1);
  end
  always_ff @(posedge clk or posedge ap_rst)
    if (ap_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  spmv_dp_regfile #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_mem (
    .clk     (clk),
    .rst     (ap_rst),
    .i_clr   (r_state == CLEAR),
    .i_en    (r_state == RUN),
    .i_addr0 (y_address0),
    .i_ce0   (y_ce0),
    .i_we0   (y_we0),
    .i_d0    (y_d0),
    .o_q0    (y_q0),
    .i_addr1 (y_address1),
    .i_ce1   (y_ce1),
    .i_we1   (y_we1),
    .i_d1    (y_d1),
    .o_q1    (y_q1),
    .i_raddr (r_idx),
    .o_rdata (m_data)
  );
endmodule
